int_commit_arbiter: RTL and testbench
=====================================

# int_commit_arbiter

Consumer end of the integer block's commit handshake. It accepts results from the four integer pipes (MISC, ALU0, ALU1, MDU) through valid/ready and merges them onto two registered writeback ports toward the reorder buffer and physical register file. MISC gets fixed priority. The three remaining sources share the leftover slots round-robin. A saturating conflict counter is exported for performance monitoring.

## Interface
Parameters:
- PAYLOAD_W, 64: opaque per-source commit payload width (ROB index, dest tag, data, exception bits); never inspected.
- CNT_W, 32: conflict counter width.

Ports (index 0=MISC, 1=ALU0, 2=ALU1, 3=MDU):
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  pipeline flush.
- stall_i  in  1  writeback stage stall.
- src_valid_i  in  [3:0]  source has a commit entry.
- src_payload_i  in  [3:0][PAYLOAD_W-1:0]  source payload.
- src_ready_o  out  [3:0]  grant; a transfer occurs when valid&ready.
- wb_valid_o  out  [1:0]  writeback slot valid.
- wb_payload_o  out  [1:0][PAYLOAD_W-1:0]  slot payload.
- wb_src_o  out  [1:0][1:0]  source id of the slot.
- conflict_cnt_o  out  CNT_W  count of cycles in which at least one valid source was not granted.

## Operation
- Sources keep src_valid_i and src_payload_i stable until granted. src_ready_o is combinational from src_valid_i, the rr pointer, flush_i and stall_i.
- Grants are issued only when flush_i=0 and stall_i=0. Otherwise src_ready_o=0.
- Slot filling, at most 2 grants per cycle:
  - If MISC is valid, it is granted and takes slot 0.
  - The remaining slots go to valid sources from {ALU0, ALU1, MDU}, scanned cyclically starting at rr.
  - The first granted source goes to slot 0 (if still free), then slot 1.
- rr (2-bit, values 1..3) update:
  - rr moves to the source after the last granted non-MISC source, cyclically: after 3 comes 1.
  - If no non-MISC source is granted, rr is unchanged.
- Writeback registers on a grant cycle:
  - Each slot is loaded with valid=1, the granted payload, and its source id.
  - Unused slots get valid=0. Payload and src in unused slots are don't-care but hold their previous value.
- During stall_i=1 with no flush, all wb_* outputs hold. Downstream consumes a slot in the cycle where wb_valid_o=1 and stall_i=0.
- On flush_i=1:
  - wb_valid_o is cleared to 0 on the next edge and no grants are issued.
  - rr and conflict_cnt_o are unchanged.
  - Flush overrides stall.
- conflict_cnt_o:
  - Increments when flush_i=0 and (src_valid_i & ~src_ready_o) != 0. This includes cycles blocked by stall.
  - It saturates at all-ones.
- Reset (rst=1 at an edge): wb_valid_o=0, wb_payload_o=0, wb_src_o=0, rr=1, conflict_cnt_o=0. Reset has priority over flush and stall. src_ready_o is 0 while rst=1.

## Timing
- Latency: a source granted in cycle N appears on wb_* in cycle N+1.
- Throughput: 2 commits per cycle when not stalled.
- A slot that is not stalled is valid for exactly one cycle per grant. There is no combinational path from src_* to wb_*.
- Simultaneous events:
  - Flush and a valid source in the same cycle: no grant, and the source must re-present after the flush.
  - Stall then flush: held slots are dropped.
  - Reset mid-stall: all outputs return to their reset values.
- Boundary: with 4 sources valid, 2 are granted and 2 wait. The conflict count increments by 1 per such cycle, not by 2.

## Test plan
- Reset, then all sources idle for 5 cycles:
  - src_ready_o=0 and wb_valid_o=0 throughout.
  - conflict_cnt_o=0.
- MISC, ALU0, ALU1 and MDU all valid and held for 3 cycles, rr=1. Grants must be:
  - cycle 0: {MISC, ALU0}
  - cycle 1: {MISC, ALU1}
  - cycle 2: {MISC, MDU}
  - wb_src_o slot0=0 each cycle; slot1=1, 2, 3 on successive cycles.
  - conflict_cnt_o=3.
- ALU0 and MDU valid, MISC idle, rr=1:
  - wb slot0 src=1, slot1 src=3, both valid in cycle N+1.
  - rr becomes 1 (wrap).
- ALU1 granted in cycle N, then stall_i=1 in cycles N+1..N+3:
  - wb_valid_o=01 with the payload held through N+3.
  - No src_ready_o during N+1..N+3.
  - conflict_cnt_o increments only in cycles where a source is valid.
- flush_i=1 while wb_valid_o=11 and ALU0 valid:
  - Next cycle wb_valid_o=00 and src_ready_o=0 during the flush.
  - ALU0 is granted in the first cycle after the flush.
- Preload conflict_cnt_o to all-ones (or use CNT_W=4 and run 20 conflict cycles):
  - The counter holds at all-ones (15 for CNT_W=4) and does not wrap.

Source files
------------

// File: rtl/int_commit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : int_commit_arbiter
//  Purpose  : Merges four integer-pipe commit streams onto two registered
//             writeback slots; MISC has fixed priority, ALU0/ALU1/MDU share
//             the remaining slots round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module int_commit_arbiter #(
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      stall_i,
  input  logic [3:0]                src_valid_i,
  input  logic [3:0][PAYLOAD_W-1:0] src_payload_i,
  output logic [3:0]                src_ready_o,
  output logic [1:0]                wb_valid_o,
  output logic [1:0][PAYLOAD_W-1:0] wb_payload_o,
  output logic [1:0][1:0]           wb_src_o,
  output logic [CNT_W-1:0]          conflict_cnt_o
);

  localparam logic [1:0] RR_FIRST = 2'd1;

  logic [1:0]                rr;
  logic [1:0]                rr_next;
  logic [1:0]                scan_src;
  logic                      grant_en;
  logic                      conflict;
  logic [1:0]                slot_vld;
  logic [1:0][1:0]           slot_src;
  logic [1:0][PAYLOAD_W-1:0] slot_pay;

  // Round-robin successor within the shared pool {1,2,3}.
  function automatic logic [1:0] next_shared(input logic [1:0] s);
    return (s == 2'd3) ? 2'd1 : s + 2'd1;
  endfunction

  assign grant_en = ~rst & ~flush_i & ~stall_i;

  always_comb begin
    src_ready_o = '0;
    slot_vld    = '0;
    slot_src    = '0;
    rr_next     = rr;
    scan_src    = rr;
    if (grant_en) begin
      if (src_valid_i[0]) begin
        src_ready_o[0] = 1'b1;
        slot_vld[0]    = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
        if (src_valid_i[scan_src] && !slot_vld[1]) begin
          src_ready_o[scan_src] = 1'b1;
          if (!slot_vld[0]) begin
            slot_vld[0] = 1'b1;
            slot_src[0] = scan_src;
          end else begin
            slot_vld[1] = 1'b1;
            slot_src[1] = scan_src;
          end
          rr_next = next_shared(scan_src);
        end
        scan_src = next_shared(scan_src);
      end
    end
  end

  generate
    for (genvar i = 0; i < 2; i++) begin : g_slot_mux
      assign slot_pay[i] = src_payload_i[slot_src[i]];
    end
  endgenerate

  // Stall-blocked sources count as conflicts; flush cycles never do.
  assign conflict = ~flush_i & (|(src_valid_i & ~src_ready_o));

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_o     <= '0;
      wb_payload_o   <= '0;
      wb_src_o       <= '0;
      rr             <= RR_FIRST;
      conflict_cnt_o <= '0;
    end else begin
      if (conflict && (conflict_cnt_o != '1)) begin
        conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
      end
      if (flush_i) begin
        wb_valid_o <= '0;
      end else if (!stall_i) begin
        wb_valid_o <= slot_vld;
        rr         <= rr_next;
        for (int i = 0; i < 2; i++) begin
          if (slot_vld[i]) begin
            wb_payload_o[i] <= slot_pay[i];
            wb_src_o[i]     <= slot_src[i];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_commit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_commit_arbiter
//  Purpose  : Self-checking bench for int_commit_arbiter (directed + random).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_commit_arbiter;

  localparam int PW = 32;
  localparam int CW = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                stall;
  logic [3:0]          src_valid;
  logic [3:0][PW-1:0]  src_payload;
  logic [3:0]          src_ready;
  logic [1:0]          wb_valid;
  logic [1:0][PW-1:0]  wb_payload;
  logic [1:0][1:0]     wb_src;
  logic [CW-1:0]       conflict_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [1:0]         m_wbv;
  logic [1:0][PW-1:0] m_wbp;
  logic [1:0][1:0]    m_wbs;
  int                 m_rr;
  logic [CW-1:0]      m_cnt;
  logic [3:0]         m_ready;

  always #5 clk = ~clk;

  int_commit_arbiter #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .stall_i        (stall),
    .src_valid_i    (src_valid),
    .src_payload_i  (src_payload),
    .src_ready_o    (src_ready),
    .wb_valid_o     (wb_valid),
    .wb_payload_o   (wb_payload),
    .wb_src_o       (wb_src),
    .conflict_cnt_o (conflict_cnt)
  );

  // Grant selection straight from the rules: MISC first, then shared pool
  // visited in order rr, rr+1, rr+2 (mod 3, values 1..3) until two slots fill.
  function automatic void pick(input logic [3:0] v, input int rr,
                               output logic [3:0] g, output int s0,
                               output int s1, output int n, output int rr_n);
    int id;
    g = '0; s0 = 0; s1 = 0; n = 0; rr_n = rr;
    if (v[0]) begin g[0] = 1'b1; s0 = 0; n = 1; end
    for (int k = 0; k < 3; k++) begin
      id = ((rr - 1 + k) % 3) + 1;
      if (v[id] && n < 2) begin
        g[id] = 1'b1;
        if (n == 0) s0 = id; else s1 = id;
        n = n + 1;
        rr_n = (id % 3) + 1;
      end
    end
  endfunction

  function automatic void calc_ready();
    logic [3:0] g; int s0, s1, n, rrn;
    pick(src_valid, m_rr, g, s0, s1, n, rrn);
    m_ready = (rst || flush || stall) ? 4'b0 : g;
  endfunction

  function automatic void model_edge();
    logic [3:0] g; int s0, s1, n, rrn;
    if (rst) begin
      m_wbv = '0; m_wbp = '0; m_wbs = '0; m_rr = 1; m_cnt = '0;
      return;
    end
    pick(src_valid, m_rr, g, s0, s1, n, rrn);
    if (flush || stall) g = '0;
    if (!flush && ((src_valid & ~g) != 4'b0) && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    if (flush) begin
      m_wbv = '0;
    end else if (!stall) begin
      m_wbv = {n == 2, n >= 1};
      if (n >= 1) begin m_wbp[0] = src_payload[s0]; m_wbs[0] = 2'(s0); end
      if (n == 2) begin m_wbp[1] = src_payload[s1]; m_wbs[1] = 2'(s1); end
      m_rr = rrn;
    end
  endfunction

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; stall = 1'b0; src_valid = '0;
    advance();
    rst = 1'b0;
  endtask

  task automatic set_payloads();
    for (int i = 0; i < 4; i++) src_payload[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (src_ready !== 4'b0) begin failures++; $display("FAIL rst_ready: got %b expected 0000", src_ready); end
    advance();
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b0 || wb_payload !== '0 || wb_src !== '0 || conflict_cnt !== '0) begin
      failures++;
      $display("FAIL rst_outputs: got v=%b p=%h s=%h c=%0d expected all zero", wb_valid, wb_payload, wb_src, conflict_cnt);
    end
    advance();
    rst = 1'b0; src_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (src_ready !== 4'b0 || wb_valid !== 2'b0) begin
        failures++;
        $display("FAIL idle_cycle%0d: got ready=%b wb_valid=%b expected 0000/00", c, src_ready, wb_valid);
      end
      advance();
    end
    checks++;
    if (conflict_cnt !== '0) begin failures++; $display("FAIL idle_cnt: got %0d expected 0", conflict_cnt); end
  endtask

  task automatic test_all_valid();
    logic [3:0] tbl [3];
    tbl[0] = 4'b0011; tbl[1] = 4'b0101; tbl[2] = 4'b1001;
    do_reset();
    set_payloads();
    src_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (src_ready !== tbl[c]) begin failures++; $display("FAIL allv_ready%0d: got %b expected %b", c, src_ready, tbl[c]); end
      if (c > 0) begin
        checks++;
        if (wb_valid !== 2'b11 || wb_src[0] !== 2'd0 || wb_src[1] !== 2'(c)) begin
          failures++;
          $display("FAIL allv_wb%0d: got v=%b s0=%0d s1=%0d expected 11/0/%0d", c, wb_valid, wb_src[0], wb_src[1], c);
        end
      end
      advance();
    end
    src_valid = '0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b11 || wb_src[1] !== 2'd3 || wb_payload[1] !== src_payload[3] || wb_payload[0] !== src_payload[0]) begin
      failures++;
      $display("FAIL allv_last: got v=%b s1=%0d p1=%h expected 11/3/%h", wb_valid, wb_src[1], wb_payload[1], src_payload[3]);
    end
    checks++;
    if (conflict_cnt !== 4'd3) begin failures++; $display("FAIL allv_cnt: got %0d expected 3", conflict_cnt); end
    advance();
  endtask

  task automatic test_wrap();
    do_reset();
    set_payloads();
    src_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (src_ready !== 4'b1010) begin failures++; $display("FAIL wrap_ready: got %b expected 1010", src_ready); end
    advance();
    src_valid = 4'b0111;
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b11 || wb_src[0] !== 2'd1 || wb_src[1] !== 2'd3 ||
        wb_payload[0] !== src_payload[1] || wb_payload[1] !== src_payload[3]) begin
      failures++;
      $display("FAIL wrap_wb: got v=%b s0=%0d s1=%0d expected 11/1/3", wb_valid, wb_src[0], wb_src[1]);
    end
    checks++;
    if (src_ready !== 4'b0011) begin failures++; $display("FAIL wrap_rr: got %b expected 0011", src_ready); end
    advance();
    src_valid = '0;
    @(negedge clk);
    checks++;
    if (conflict_cnt !== 4'd1) begin failures++; $display("FAIL wrap_cnt: got %0d expected 1", conflict_cnt); end
    advance();
  endtask

  task automatic test_stall();
    do_reset();
    set_payloads();
    src_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (src_ready !== 4'b0100) begin failures++; $display("FAIL stall_grant: got %b expected 0100", src_ready); end
    advance();
    src_valid = '0; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k >= 1) src_valid = 4'b0010;
      @(negedge clk);
      checks++;
      if (wb_valid !== 2'b01 || wb_src[0] !== 2'd2 || wb_payload[0] !== src_payload[2] || src_ready !== 4'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: got v=%b s0=%0d rdy=%b expected 01/2/0000", k, wb_valid, wb_src[0], src_ready);
      end
      advance();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (conflict_cnt !== 4'd2) begin failures++; $display("FAIL stall_cnt: got %0d expected 2", conflict_cnt); end
    checks++;
    if (src_ready !== 4'b0010) begin failures++; $display("FAIL stall_release: got %b expected 0010", src_ready); end
    advance();
    src_valid = '0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b01 || wb_src[0] !== 2'd1) begin
      failures++;
      $display("FAIL stall_after: got v=%b s0=%0d expected 01/1", wb_valid, wb_src[0]);
    end
    advance();
  endtask

  task automatic test_flush();
    do_reset();
    set_payloads();
    src_valid = 4'b0011;
    advance();
    flush = 1'b1; stall = 1'b1; src_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b11 || src_ready !== 4'b0) begin
      failures++;
      $display("FAIL flush_during: got v=%b rdy=%b expected 11/0000", wb_valid, src_ready);
    end
    advance();
    flush = 1'b0; stall = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b00 || src_ready !== 4'b0010 || conflict_cnt !== '0) begin
      failures++;
      $display("FAIL flush_after: got v=%b rdy=%b cnt=%0d expected 00/0010/0", wb_valid, src_ready, conflict_cnt);
    end
    advance();
    src_valid = '0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 2'b01 || wb_src[0] !== 2'd1 || wb_payload[0] !== src_payload[1]) begin
      failures++;
      $display("FAIL flush_regrant: got v=%b s0=%0d expected 01/1", wb_valid, wb_src[0]);
    end
    advance();
  endtask

  task automatic test_saturate();
    int exp;
    do_reset();
    src_valid = 4'hF; stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      advance();
      @(negedge clk);
      exp = (i > 15) ? 15 : i;
      checks++;
      if (conflict_cnt !== 4'(exp)) begin failures++; $display("FAIL sat_cnt%0d: got %0d expected %0d", i, conflict_cnt, exp); end
    end
    stall = 1'b0; src_valid = '0;
    advance();
  endtask

  task automatic test_random();
    logic [3:0] g;
    do_reset();
    src_valid = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      calc_ready();
      checks++;
      if (src_ready !== m_ready) begin failures++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, src_ready, m_ready); end
      checks++;
      if (wb_valid !== m_wbv || wb_src !== m_wbs || wb_payload !== m_wbp) begin
        failures++;
        $display("FAIL rnd_wb@%0d: got v=%b s=%h p=%h expected v=%b s=%h p=%h", cyc, wb_valid, wb_src, wb_payload, m_wbv, m_wbs, m_wbp);
      end
      checks++;
      if (conflict_cnt !== m_cnt) begin failures++; $display("FAIL rnd_cnt@%0d: got %0d expected %0d", cyc, conflict_cnt, m_cnt); end
      g = m_ready;
      advance();
      for (int i = 0; i < 4; i++) begin
        if (!src_valid[i] || g[i]) begin
          src_valid[i]   = ($urandom_range(0, 2) != 0);
          src_payload[i] = $urandom;
        end
      end
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      rst   = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0; flush = 1'b0; stall = 1'b0; src_valid = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; src_valid = '0; src_payload = '0;
    model_edge();
    test_reset();
    test_all_valid();
    test_wrap();
    test_stall();
    test_flush();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
